// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  // FSM encoding, also used for the debug state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Width of the word index into a memory of 'depth' words (at least 1).
  function automatic int dmem_idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // An access faults when the byte address is not word aligned or when its
  // word index lies beyond the last implemented word.
  function automatic logic dmem_fault(input logic [31:0] addr,
                                      input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage data bus between the datapath (master) and the responder.
//
// Handshake: the master holds MemReqM high, with MemWriteM/ALUOutM/WriteDataM
// stable, for as long as the access occupies the M stage. The slave raises
// MemBusyM while it needs more cycles; the access completes in the first cycle
// the request is high and MemBusyM is low, where ReadDataM (load) and MemErrM
// are valid for exactly that cycle. Dropping MemReqM before completion is a
// flush: the access is abandoned with no side effects.
interface dmem_responder_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemBusyM;
  logic        MemErrM;

  modport master (
    output MemReqM, MemWriteM, ALUOutM, WriteDataM,
    input  ReadDataM, MemBusyM, MemErrM
  );

  modport slave (
    input  MemReqM, MemWriteM, ALUOutM, WriteDataM,
    output ReadDataM, MemBusyM, MemErrM
  );
endinterface

// File: rtl/dmem_responder_waitcnt.sv
// Loadable down-counter that paces the wait states of one access.
module waitcnt #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] r_cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: word-wide storage with a
// configurable number of wait states, busy/stall output and fault reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  dmem_responder_if.slave     bus,
  output dmem_state_t         o_state
);

  localparam int IDX_W = dmem_idx_width(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_addr;
  logic             r_we;
  logic [31:0]      r_data;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [1:0]       w_next_state;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic             w_cnt_zero;
  logic             w_acc_fire;
  logic [31:0]      w_acc_addr;
  logic             w_acc_we;
  logic [31:0]      w_acc_data;
  logic             w_fault;
  logic [IDX_W-1:0] w_idx;
  logic             w_mem_we;

  waitcnt #(.WIDTH(CNT_W)) u_waitcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (CNT_INIT),
    .en       (w_cnt_en),
    .zero     (w_cnt_zero)
  );

  // Pick the access that completes this cycle: the live bus when there are
  // no wait states, otherwise the captured request while in DONE.
  always_comb begin
    w_acc_fire = 1'b0;
    w_acc_addr = r_addr;
    w_acc_we   = r_we;
    w_acc_data = r_data;
    if (ZERO_WAIT) begin
      w_acc_fire = bus.MemReqM;
      w_acc_addr = bus.ALUOutM;
      w_acc_we   = bus.MemWriteM;
      w_acc_data = bus.WriteDataM;
    end else begin
      w_acc_fire = (r_state == S_DONE);
    end
  end

  assign w_fault  = dmem_fault(w_acc_addr, DEPTH_WORDS);
  assign w_idx    = w_acc_addr[IDX_W+1:2];
  // Reset low cancels a completing store so memory stays untouched.
  assign w_mem_we = reset && w_acc_fire && w_acc_we && !w_fault;

  // Response outputs; everything reads 0 while reset is asserted.
  always_comb begin
    bus.ReadDataM = '0;
    bus.MemErrM   = 1'b0;
    bus.MemBusyM  = 1'b0;
    if (reset) begin
      if (w_acc_fire && !w_acc_we && !w_fault) begin
        bus.ReadDataM = r_mem[w_idx];
      end
      bus.MemErrM  = w_acc_fire && w_fault;
      bus.MemBusyM = !ZERO_WAIT &&
                     (((r_state == S_IDLE) && bus.MemReqM) ||
                      (r_state == S_WAIT));
    end
  end

  // Next-state and counter control; a dropped request in WAIT aborts.
  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!ZERO_WAIT && bus.MemReqM) begin
          w_next_state = S_WAIT;
          w_cnt_load   = 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.MemReqM) begin
          w_next_state = S_IDLE;
        end else if (w_cnt_zero) begin
          w_next_state = S_DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the request when it is accepted out of IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr <= '0;
      r_we   <= 1'b0;
      r_data <= '0;
    end else if (w_cnt_load) begin
      r_addr <= bus.ALUOutM;
      r_we   <= bus.MemWriteM;
      r_data <= bus.WriteDataM;
    end
  end

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_acc_data;
    end
  end

  assign o_state = dmem_state_t'(r_state);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: one W=2 instance and one W=0 instance.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int W_A = 2;

  logic clk;
  logic reset;
  logic reset_b;
  dmem_state_t state_a;
  dmem_state_t state_b;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W_A)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_a),
    .o_state (state_a)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .bus     (bus_b),
    .o_state (state_b)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full access on the W=2 instance, checked every cycle until completion.
  task automatic access_a(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rd);
    logic [31:0] exp_v;
    bus_a.MemReqM    = 1'b1;
    bus_a.MemWriteM  = we;
    bus_a.ALUOutM    = addr;
    bus_a.WriteDataM = wdata;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    check("a_busy_c0", 32'(bus_a.MemBusyM), 32'd1);
    check("a_rd_c0", bus_a.ReadDataM, 32'd0);
    for (int c = 1; c <= W_A; c++) begin
      @(negedge clk);
      check("a_busy_wait", 32'(bus_a.MemBusyM), 32'd1);
      check("a_err_wait", 32'(bus_a.MemErrM), 32'd0);
      check("a_rd_wait", bus_a.ReadDataM, 32'd0);
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    check("a_busy_done", 32'(bus_a.MemBusyM), 32'd0);
    check("a_err_done", 32'(bus_a.MemErrM), 32'(exp_err));
    check("a_rd_done", bus_a.ReadDataM, exp_v);
    @(posedge clk);
    #1;
    bus_a.MemReqM    = 1'b0;
    bus_a.WriteDataM = '0;
  endtask

  // One quiet cycle on the W=2 instance.
  task automatic idle_a();
    @(negedge clk);
    check("a_idle_busy", 32'(bus_a.MemBusyM), 32'd0);
    check("a_idle_rd", bus_a.ReadDataM, 32'd0);
    check("a_idle_err", 32'(bus_a.MemErrM), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Single-cycle access on the W=0 instance.
  task automatic access_b(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rd);
    bus_b.MemReqM    = 1'b1;
    bus_b.MemWriteM  = we;
    bus_b.ALUOutM    = addr;
    bus_b.WriteDataM = wdata;
    @(negedge clk);
    check("b_busy", 32'(bus_b.MemBusyM), 32'd0);
    check("b_err", 32'(bus_b.MemErrM), 32'(exp_err));
    check("b_rd", bus_b.ReadDataM, exp_rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b0;
    reset_b          = 1'b0;
    bus_a.MemReqM    = 1'b1;
    bus_a.MemWriteM  = 1'b0;
    bus_a.ALUOutM    = 32'h10;
    bus_a.WriteDataM = '0;
    bus_b.MemReqM    = 1'b1;
    bus_b.MemWriteM  = 1'b0;
    bus_b.ALUOutM    = 32'h4;
    bus_b.WriteDataM = '0;

    // Reset held with a request present: all outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(bus_a.MemBusyM), 32'd0);
      check("rst_err", 32'(bus_a.MemErrM), 32'd0);
      check("rst_rd", bus_a.ReadDataM, 32'd0);
      check("rst_b_rd", bus_b.ReadDataM, 32'd0);
    end
    @(posedge clk);
    #1;
    reset         = 1'b1;
    reset_b       = 1'b1;
    bus_a.MemReqM = 1'b0;
    bus_b.MemReqM = 1'b0;
    @(negedge clk);
    check("rel_state", 32'(state_a), 32'(IDLE));
    check("rel_busy", 32'(bus_a.MemBusyM), 32'd0);
    @(posedge clk);
    #1;

    // Store then load.
    access_a(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    idle_a();
    access_a(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    idle_a();

    // Back-to-back store/load to the same word.
    access_a(1'b1, 32'h20, 32'h00000001, 1'b0, 32'h0);
    access_a(1'b0, 32'h20, 32'h0, 1'b0, 32'h00000001);
    idle_a();

    // Faults: misaligned store is dropped, out-of-range load errors.
    access_a(1'b1, 32'h13, 32'hFFFFFFFF, 1'b1, 32'h0);
    access_a(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    access_a(1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
    idle_a();

    // Reset in WAIT cancels the store.
    access_a(1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 32'h0);
    bus_a.MemReqM    = 1'b1;
    bus_a.MemWriteM  = 1'b1;
    bus_a.ALUOutM    = 32'h30;
    bus_a.WriteDataM = 32'h12345678;
    @(negedge clk);
    check("mr_busy_c0", 32'(bus_a.MemBusyM), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mr_state_wait", 32'(state_a), 32'(WAIT));
    check("mr_busy_rst", 32'(bus_a.MemBusyM), 32'd0);
    check("mr_err_rst", 32'(bus_a.MemErrM), 32'd0);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus_a.MemReqM = 1'b0;
    @(negedge clk);
    check("mr_state_idle", 32'(state_a), 32'(IDLE));
    @(posedge clk);
    #1;
    access_a(1'b0, 32'h30, 32'h0, 1'b0, 32'hA5A5A5A5);

    // Flush in WAIT cancels the store without an error.
    bus_a.MemReqM    = 1'b1;
    bus_a.MemWriteM  = 1'b1;
    bus_a.ALUOutM    = 32'h30;
    bus_a.WriteDataM = 32'h12345678;
    @(negedge clk);
    check("fl_busy_c0", 32'(bus_a.MemBusyM), 32'd1);
    @(posedge clk);
    #1;
    bus_a.MemReqM = 1'b0;
    @(negedge clk);
    check("fl_state_wait", 32'(state_a), 32'(WAIT));
    check("fl_busy_wait", 32'(bus_a.MemBusyM), 32'd1);
    check("fl_err_wait", 32'(bus_a.MemErrM), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fl_state_idle", 32'(state_a), 32'(IDLE));
    check("fl_err_idle", 32'(bus_a.MemErrM), 32'd0);
    check("fl_busy_idle", 32'(bus_a.MemBusyM), 32'd0);
    @(posedge clk);
    #1;
    access_a(1'b0, 32'h30, 32'h0, 1'b0, 32'hA5A5A5A5);

    // Zero-wait instance: same-cycle data, never busy.
    access_b(1'b1, 32'h4, 32'h55, 1'b0, 32'h0);
    access_b(1'b0, 32'h4, 32'h0, 1'b0, 32'h55);
    access_b(1'b0, 32'h6, 32'h0, 1'b1, 32'h0);
    access_b(1'b0, 32'h4, 32'h0, 1'b0, 32'h55);
    bus_b.MemReqM = 1'b0;
    @(negedge clk);
    check("b_idle_rd", bus_b.ReadDataM, 32'd0);
    check("b_idle_state", 32'(state_b), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
